// File: rtl/spi_dac161_responder.sv
// SPI responder modelling the DAC161 command link: oversampled SPI frame decode, DAC/preregister/power-down state.
// Define SPI_DAC161_RESP_READBACK_EN to build the SDO readback path; otherwise sdo is tied low.

module spi_dac161_responder #(
    parameter int FRAME_BITS  = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sck,
    input  logic        csb,
    input  logic        sdi,
    output logic        sdo,
    input  logic        ldacb,
    input  logic        clrb,
    output logic [15:0] dac_code,
    output logic        dac_update,
    output logic        pd,
    output logic [7:0]  frame_err_cnt
);

    localparam logic [7:0] CMD_CLR   = 8'h01;
    localparam logic [7:0] CMD_WRUP  = 8'h10;
    localparam logic [7:0] CMD_SWB   = 8'h28;
    localparam logic [7:0] CMD_LDAC  = 8'h18;
    localparam logic [7:0] CMD_PD    = 8'h30;
    localparam logic [7:0] CMD_RDDO  = 8'h88;
    localparam logic [7:0] CMD_RDIN  = 8'h98;
    localparam logic [7:0] CMD_RDCFG = 8'h90;
    localparam logic [4:0] FRAME_CNT = 5'(FRAME_BITS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_EXEC  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [SYNC_STAGES:0]   r_sck_q;
    logic [SYNC_STAGES:0]   r_csb_q;
    logic [SYNC_STAGES:0]   r_ldacb_q;
    logic [SYNC_STAGES:0]   r_clrb_q;
    logic [SYNC_STAGES-1:0] r_sdi_q;
    logic [FRAME_BITS-1:0]  r_shift;
    logic [4:0]             r_bitcnt;
    logic [15:0]            r_pre;
    logic [15:0]            r_dac;
    logic                   r_dac_update;
    logic                   r_pd;
    logic [7:0]             r_err_cnt;

    logic        w_sck_rise;
    logic        w_csb_fall;
    logic        w_csb_rise;
    logic        w_sdi_s;
    logic        w_ldacb_fall;
    logic        w_clrb_low;
    logic        w_clrb_fall;
    logic        w_exec;
    logic        w_frame_ok;
    logic        w_frame_bad;
    logic [7:0]  w_cmd;
    logic [15:0] w_data;

    assign w_sck_rise   =  r_sck_q[SYNC_STAGES-1] & ~r_sck_q[SYNC_STAGES];
    assign w_csb_fall   = ~r_csb_q[SYNC_STAGES-1] &  r_csb_q[SYNC_STAGES];
    assign w_csb_rise   =  r_csb_q[SYNC_STAGES-1] & ~r_csb_q[SYNC_STAGES];
    assign w_sdi_s      =  r_sdi_q[SYNC_STAGES-1];
    assign w_ldacb_fall = ~r_ldacb_q[SYNC_STAGES-1] & r_ldacb_q[SYNC_STAGES];
    assign w_clrb_low   = ~r_clrb_q[SYNC_STAGES-1];
    assign w_clrb_fall  = ~r_clrb_q[SYNC_STAGES-1] & r_clrb_q[SYNC_STAGES];
    assign w_exec       = (r_state == ST_EXEC);
    assign w_frame_ok   = w_exec && (r_bitcnt == FRAME_CNT);
    assign w_frame_bad  = w_exec && (r_bitcnt != FRAME_CNT);
    assign w_cmd        = r_shift[FRAME_BITS-1 -: 8];
    assign w_data       = r_shift[15:0];

    // Input synchronizers; csb and ldacb reset low so a line already low at release is not seen as a falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sck_q   <= '0;
            r_csb_q   <= '0;
            r_ldacb_q <= '0;
            r_clrb_q  <= '1;
            r_sdi_q   <= '0;
        end else begin
            r_sck_q   <= {r_sck_q[SYNC_STAGES-1:0], sck};
            r_csb_q   <= {r_csb_q[SYNC_STAGES-1:0], csb};
            r_ldacb_q <= {r_ldacb_q[SYNC_STAGES-1:0], ldacb};
            r_clrb_q  <= {r_clrb_q[SYNC_STAGES-1:0], clrb};
            r_sdi_q   <= {r_sdi_q[SYNC_STAGES-2:0], sdi};
        end
    end

    // Frame FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Frame FSM next state; a csb fall seen during EXEC chains straight into the next frame.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_csb_fall) w_state_nxt = ST_SHIFT;
                else            w_state_nxt = ST_IDLE;
            end
            ST_SHIFT: begin
                if (w_csb_rise) w_state_nxt = ST_EXEC;
                else            w_state_nxt = ST_SHIFT;
            end
            ST_EXEC: begin
                if (w_csb_fall) w_state_nxt = ST_SHIFT;
                else            w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Shift register and saturating bit counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift  <= '0;
            r_bitcnt <= 5'd0;
        end else if (w_csb_fall) begin
            r_shift  <= '0;
            r_bitcnt <= 5'd0;
        end else if ((r_state == ST_SHIFT) && w_sck_rise) begin
            r_shift <= {r_shift[FRAME_BITS-2:0], w_sdi_s};
            if (r_bitcnt != 5'd31) r_bitcnt <= r_bitcnt + 5'd1;
        end
    end

    // Preregister / DAC register; clrb overrides a frame command, which in turn overrides an ldacb edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre        <= 16'd0;
            r_dac        <= 16'd0;
            r_dac_update <= 1'b0;
        end else begin
            r_dac_update <= 1'b0;
            if (w_clrb_low) begin
                r_pre        <= 16'd0;
                r_dac        <= 16'd0;
                r_dac_update <= w_clrb_fall;
            end else if (w_frame_ok) begin
                case (w_cmd)
                    CMD_CLR: begin
                        r_pre        <= 16'd0;
                        r_dac        <= 16'd0;
                        r_dac_update <= 1'b1;
                    end
                    CMD_WRUP: r_pre <= w_data;
                    CMD_SWB: begin
                        r_pre        <= w_data;
                        r_dac        <= w_data;
                        r_dac_update <= 1'b1;
                    end
                    CMD_LDAC: begin
                        if (w_data[0]) begin
                            r_dac        <= r_pre;
                            r_dac_update <= 1'b1;
                        end
                    end
                    default: r_pre <= r_pre;
                endcase
            end else if (w_ldacb_fall) begin
                r_dac        <= r_pre;
                r_dac_update <= 1'b1;
            end
        end
    end

    // Power-down flag and malformed-frame counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pd      <= 1'b1;
            r_err_cnt <= 8'd0;
        end else begin
            if (w_frame_ok && (w_cmd == CMD_PD)) r_pd <= w_data[0];
            if (w_frame_bad && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign dac_code      = r_dac;
    assign dac_update    = r_dac_update;
    assign pd            = r_pd;
    assign frame_err_cnt = r_err_cnt;

`ifdef SPI_DAC161_RESP_READBACK_EN
    logic [23:0] r_rb;
    logic        r_sdo;
    logic        w_sck_fall;

    assign w_sck_fall = ~r_sck_q[SYNC_STAGES-1] & r_sck_q[SYNC_STAGES];

    // Readback register: loaded in EXEC by a read, otherwise cleared once the frame has consumed it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rb  <= 24'd0;
            r_sdo <= 1'b0;
        end else begin
            if (w_exec) begin
                if (w_frame_ok) begin
                    case (w_cmd)
                        CMD_RDDO:  r_rb <= {CMD_RDDO, r_pre};
                        CMD_RDIN:  r_rb <= {CMD_RDIN, r_dac};
                        CMD_RDCFG: r_rb <= {CMD_RDCFG, 15'd0, r_pd};
                        default:   r_rb <= 24'd0;
                    endcase
                end else begin
                    r_rb <= 24'd0;
                end
            end else if ((r_state == ST_SHIFT) && w_sck_fall) begin
                r_rb <= {r_rb[22:0], 1'b0};
            end
            if ((r_state == ST_SHIFT) && w_sck_fall) r_sdo <= r_rb[22];
            else                                     r_sdo <= r_rb[23];
        end
    end

    assign sdo = r_sdo;
`else
    assign sdo = 1'b0;
`endif

endmodule
